// File: rtl/bb_sequencer.sv
// bb_sequencer -- fetch/execute sequencer for the black_bean core.
//
// Fetches one instruction byte from mem[PC] into IR, decodes it and executes it
// as a single bus transfer by steering the register-controller and ALU enables.
// Memory access is a one-outstanding read/write handshake completed by
// i_mem_ready.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   i_start                start pulse, honoured only in IDLE/HALT
//   i_data                 shared data bus (instruction byte during fetch)
//   i_mem_ready            memory completes the current access this cycle
//   o_unit_reg_input_en    one-hot register write enable (1 AR, 2 DR0, 3 DR1, 5 PC)
//   o_unit_reg_output_en   one-hot register bus drive enable (same map)
//   o_unit_alu_output_en   one-hot ALU function/drive select
//   o_mem_addr_source      1 = address from PC, 0 = address from AR
//   o_pc_counter_en        PC increment strobe
//   o_mem_rd, o_mem_wr     memory read / write requests
//   o_ir                   instruction register
//   o_busy, o_halted       status
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | after reset, IR cleared, all outputs low, waits for i_start
// FETCH | read mem[PC] until i_mem_ready, latch IR, bump PC
// EXEC  | one-cycle decode; MOVE/ALU finish here, LOAD/STORE go to MEM
// MEM   | LOAD/STORE data transfer at mem[AR] until i_mem_ready
// HALT  | IR = 8'hFF executed, waits for i_start

module bb_sequencer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_mem_ready,
    output logic [5:0]            o_unit_reg_input_en,
    output logic [5:0]            o_unit_reg_output_en,
    output logic [5:0]            o_unit_alu_output_en,
    output logic                  o_mem_addr_source,
    output logic                  o_pc_counter_en,
    output logic                  o_mem_rd,
    output logic                  o_mem_wr,
    output logic [DATA_WIDTH-1:0] o_ir,
    output logic                  o_busy,
    output logic                  o_halted
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    localparam logic [1:0] CLS_MOVE  = 2'b00;
    localparam logic [1:0] CLS_LOAD  = 2'b01;
    localparam logic [1:0] CLS_STORE = 2'b10;
    localparam logic [1:0] CLS_ALU   = 2'b11;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] ir_q, ir_d;

    logic [1:0] ir_cls;
    logic [2:0] ir_src;
    logic [2:0] ir_dst;
    logic       ir_is_halt;

    // Indices 6 and 7 select no unit at all.
    function automatic logic [5:0] unit_onehot(input logic [2:0] idx);
        logic [5:0] res;
        res = 6'd0;
        if (idx < 3'd6) begin
            res[idx] = 1'b1;
        end
        return res;
    endfunction

    // Only the low byte of IR is decoded; wider IR bits are carried but ignored.
    assign ir_cls     = ir_q[7:6];
    assign ir_src     = ir_q[5:3];
    assign ir_dst     = ir_q[2:0];
    assign ir_is_halt = (ir_q[7:0] == 8'hFF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d              = state_q;
        ir_d                 = ir_q;
        o_unit_reg_input_en  = 6'd0;
        o_unit_reg_output_en = 6'd0;
        o_unit_alu_output_en = 6'd0;
        o_mem_addr_source    = 1'b0;
        o_pc_counter_en      = 1'b0;
        o_mem_rd             = 1'b0;
        o_mem_wr             = 1'b0;
        o_busy               = 1'b0;
        o_halted             = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_FETCH;
                end
            end

            S_HALT: begin
                o_halted = 1'b1;
                if (i_start) begin
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                o_busy            = 1'b1;
                o_mem_rd          = 1'b1;
                o_mem_addr_source = 1'b1;
                if (i_mem_ready) begin
                    o_pc_counter_en = 1'b1;
                    ir_d            = i_data;
                    state_d         = S_EXEC;
                end
            end

            S_EXEC: begin
                o_busy = 1'b1;
                case (ir_cls)
                    CLS_MOVE: begin
                        o_unit_reg_output_en = unit_onehot(ir_src);
                        o_unit_reg_input_en  = unit_onehot(ir_dst);
                        state_d              = S_FETCH;
                    end
                    CLS_ALU: begin
                        if (ir_is_halt) begin
                            state_d = S_HALT;
                        end else begin
                            o_unit_alu_output_en = unit_onehot(ir_src);
                            o_unit_reg_input_en  = unit_onehot(ir_dst);
                            state_d              = S_FETCH;
                        end
                    end
                    default: begin
                        state_d = S_MEM;
                    end
                endcase
            end

            S_MEM: begin
                o_busy = 1'b1;
                if (ir_cls == CLS_LOAD) begin
                    o_mem_rd = 1'b1;
                    // The destination captures the bus only once the data is valid.
                    if (i_mem_ready) begin
                        o_unit_reg_input_en = unit_onehot(ir_dst);
                    end
                end else if (ir_cls == CLS_STORE) begin
                    o_mem_wr             = 1'b1;
                    o_unit_reg_output_en = unit_onehot(ir_src);
                end
                if (i_mem_ready) begin
                    state_d = S_FETCH;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_ir = ir_q;

endmodule

// File: tb/tb_bb_sequencer.sv
// Testbench for bb_sequencer. Each instruction is expanded by the bench into its
// expected cycle-by-cycle output trace (fetch waits, fetch ready, exec, memory
// waits, memory ready, halt) and compared with the DUT every cycle.

module tb_bb_sequencer;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic          i_mem_ready = 1'b0;
    logic [5:0]    o_unit_reg_input_en;
    logic [5:0]    o_unit_reg_output_en;
    logic [5:0]    o_unit_alu_output_en;
    logic          o_mem_addr_source;
    logic          o_pc_counter_en;
    logic          o_mem_rd;
    logic          o_mem_wr;
    logic [DW-1:0] o_ir;
    logic          o_busy;
    logic          o_halted;

    bb_sequencer #(.DATA_WIDTH(DW)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .i_start              (i_start),
        .i_data               (i_data),
        .i_mem_ready          (i_mem_ready),
        .o_unit_reg_input_en  (o_unit_reg_input_en),
        .o_unit_reg_output_en (o_unit_reg_output_en),
        .o_unit_alu_output_en (o_unit_alu_output_en),
        .o_mem_addr_source    (o_mem_addr_source),
        .o_pc_counter_en      (o_pc_counter_en),
        .o_mem_rd             (o_mem_rd),
        .o_mem_wr             (o_mem_wr),
        .o_ir                 (o_ir),
        .o_busy               (o_busy),
        .o_halted             (o_halted)
    );

    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_mis = 0;
    logic [DW-1:0] ir_m = '0;
    logic [23:0]   obs_vec;

    assign obs_vec = {o_unit_reg_input_en, o_unit_reg_output_en, o_unit_alu_output_en,
                      o_mem_addr_source, o_pc_counter_en, o_mem_rd, o_mem_wr,
                      o_busy, o_halted};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] oh(input int n);
        return (n < 6) ? 6'(1 << n) : 6'd0;
    endfunction

    function automatic logic [23:0] pk(input logic [5:0] ri, input logic [5:0] ro,
                                       input logic [5:0] ra, input logic src,
                                       input logic pc, input logic rd, input logic wr,
                                       input logic busy, input logic halt);
        return {ri, ro, ra, src, pc, rd, wr, busy, halt};
    endfunction

    // One clock cycle: drive at the falling edge, check shortly after.
    task automatic step(input logic rdy, input logic [DW-1:0] dat, input logic st,
                        input logic [23:0] ev, input string tag);
        @(negedge clk);
        i_mem_ready = rdy;
        i_data      = dat;
        i_start     = st;
        #2;
        chk(tag, 32'(obs_vec), 32'(ev));
        chk({tag, "_ir"}, 32'(o_ir), 32'(ir_m));
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [DW-1:0] rbyte();
        return DW'($urandom_range(0, 255));
    endfunction

    // Runs one instruction from its fetch through to completion. A HALT also
    // sits in HALT for a few cycles and is then restarted.
    task automatic run_instr(input logic [7:0] ir, input int fw, input int mw);
        int          src;
        int          dst;
        logic [1:0]  cls;
        logic [23:0] ev;
        src = int'(ir[5:3]);
        dst = int'(ir[2:0]);
        cls = ir[7:6];

        for (int i = 0; i < fw; i++)
            step(1'b0, rbyte(), rbit(), pk(0, 0, 0, 1, 0, 1, 0, 1, 0), "fetch_wait");
        step(1'b1, DW'(ir), rbit(), pk(0, 0, 0, 1, 1, 1, 0, 1, 0), "fetch_rdy");
        ir_m = DW'(ir);

        if (cls == 2'b00)
            ev = pk(oh(dst), oh(src), 0, 0, 0, 0, 0, 1, 0);
        else if (cls == 2'b11 && ir == 8'hFF)
            ev = pk(0, 0, 0, 0, 0, 0, 0, 1, 0);
        else if (cls == 2'b11)
            ev = pk(oh(dst), 0, oh(src), 0, 0, 0, 0, 1, 0);
        else
            ev = pk(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(rbit(), rbyte(), rbit(), ev, "exec");

        if (cls == 2'b01) begin
            for (int i = 0; i < mw; i++)
                step(1'b0, rbyte(), rbit(), pk(0, 0, 0, 0, 0, 1, 0, 1, 0), "load_wait");
            step(1'b1, rbyte(), rbit(), pk(oh(dst), 0, 0, 0, 0, 1, 0, 1, 0), "load_rdy");
        end else if (cls == 2'b10) begin
            for (int i = 0; i < mw; i++)
                step(1'b0, rbyte(), rbit(), pk(0, oh(src), 0, 0, 0, 0, 1, 1, 0), "store_wait");
            step(1'b1, rbyte(), rbit(), pk(0, oh(src), 0, 0, 0, 0, 1, 1, 0), "store_rdy");
        end else if (ir == 8'hFF) begin
            int hw;
            hw = $urandom_range(1, 3);
            for (int i = 0; i < hw; i++)
                step(rbit(), rbyte(), 1'b0, pk(0, 0, 0, 0, 0, 0, 0, 0, 1), "halted");
            step(rbit(), rbyte(), 1'b1, pk(0, 0, 0, 0, 0, 0, 0, 0, 1), "halt_start");
        end
    endtask

    initial begin
        logic [7:0] r;
        int         fw;
        int         mw;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        step(1'b1, rbyte(), 1'b0, pk(0, 0, 0, 0, 0, 0, 0, 0, 0), "idle");
        step(1'b1, rbyte(), 1'b1, pk(0, 0, 0, 0, 0, 0, 0, 0, 0), "idle_start");

        // MOVE DR0 -> DR1 with zero-wait memory, leaving a non-zero IR
        run_instr(8'b00_010_011, 0, 0);

        // Reset arriving in the middle of an open fetch
        step(1'b0, rbyte(), 1'b0, pk(0, 0, 0, 1, 0, 1, 0, 1, 0), "fetch_pre_rst");
        #1 rst_n = 1'b0;
        #1;
        ir_m = '0;
        chk("rst_async_out", 32'(obs_vec), 32'd0);
        chk("rst_async_ir", 32'(o_ir), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, rbyte(), 1'b0, pk(0, 0, 0, 0, 0, 0, 0, 0, 0), "idle_after_rst");
        step(1'b0, rbyte(), 1'b1, pk(0, 0, 0, 0, 0, 0, 0, 0, 0), "restart");

        // Directed programme
        run_instr(8'h41, 0, 3);          // LOAD mem -> AR, three wait cycles
        run_instr(8'b10_011_000, 1, 2);  // STORE DR1 -> mem
        run_instr(8'b11_001_010, 0, 0);  // ALU fn1 -> DR0
        run_instr(8'b00_001_101, 0, 0);  // MOVE AR -> PC (jump)
        run_instr(8'hFF, 0, 0);          // HALT
        run_instr(8'b00_110_111, 2, 0);  // illegal indices: no enables
        run_instr(8'b01_000_101, 0, 1);  // LOAD into PC

        // Random programme
        for (int k = 0; k < 60; k++) begin
            r = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0) r = 8'hFF;
            fw = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
            mw = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
            run_instr(r, fw, mw);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
